// File: rtl/cic_comb_section_if.sv
// Sample stream interface for the CIC comb section: enable, input samples and output samples.
interface cic_comb_section_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             ena;
    logic             in_valid;
    logic [WIDTH-1:0] x_in;
    logic             out_valid;
    logic [WIDTH-1:0] y_out;

    modport master (
        output ena,
        output in_valid,
        output x_in,
        input  out_valid,
        input  y_out
    );

    modport slave (
        input  ena,
        input  in_valid,
        input  x_in,
        output out_valid,
        output y_out
    );
endinterface

// File: rtl/cic_comb_section.sv
// CIC comb section: STAGES cascaded registered combs y[n] = x[n] - x[n-DELAY], modular arithmetic.
module cic_comb_section #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 3,
    parameter int unsigned DELAY  = 1
) (
    input logic               clock,
    input logic               reset,
    cic_comb_section_if.slave bus
);

    logic [WIDTH-1:0] y_stage [STAGES];
    logic             v_stage [STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] dly_q [DELAY];
        logic [WIDTH-1:0] y_q;
        logic             v_q;
        logic [WIDTH-1:0] stg_in;
        logic             stg_vin;

        if (k == 0) begin : g_first
            assign stg_in  = bus.x_in;
            assign stg_vin = bus.in_valid;
        end else begin : g_next
            assign stg_in  = y_stage[k-1];
            assign stg_vin = v_stage[k-1];
        end

        // The delay line only advances on valid samples, so input gaps never alter the response.
        always_ff @(posedge clock) begin
            if (reset) begin
                y_q <= '0;
                v_q <= 1'b0;
                for (int j = 0; j < int'(DELAY); j++) begin
                    dly_q[j] <= '0;
                end
            end else if (bus.ena) begin
                v_q <= stg_vin;
                if (stg_vin) begin
                    y_q      <= stg_in - dly_q[DELAY-1];
                    dly_q[0] <= stg_in;
                    for (int j = 1; j < int'(DELAY); j++) begin
                        dly_q[j] <= dly_q[j-1];
                    end
                end
            end
        end

        assign y_stage[k] = y_q;
        assign v_stage[k] = v_q;
    end

    assign bus.y_out     = y_stage[STAGES-1];
    assign bus.out_valid = v_stage[STAGES-1];

endmodule

// File: tb/tb_cic_comb_section.sv
// Directed bench for cic_comb_section: impulse/step/gap/enable/reset on a 3-stage comb,
// differential delay and wrap-around on single-stage combs.
module tb_cic_comb_section;

    logic clock;
    logic reset;

    int unsigned n_cmp;
    int unsigned n_err;

    cic_comb_section_if #(.WIDTH(16)) imp_if  ();
    cic_comb_section_if #(.WIDTH(16)) dly_if  ();
    cic_comb_section_if #(.WIDTH(16)) wrap_if ();

    cic_comb_section #(.WIDTH(16), .STAGES(3), .DELAY(1)) u_imp (
        .clock (clock),
        .reset (reset),
        .bus   (imp_if)
    );

    cic_comb_section #(.WIDTH(16), .STAGES(1), .DELAY(2)) u_dly (
        .clock (clock),
        .reset (reset),
        .bus   (dly_if)
    );

    cic_comb_section #(.WIDTH(16), .STAGES(1), .DELAY(1)) u_wrap (
        .clock (clock),
        .reset (reset),
        .bus   (wrap_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    // Collect 3-stage outputs produced on enabled edges only; frozen outputs are not new samples.
    logic        imp_ena_seen;
    logic [15:0] got_q [$];
    logic [15:0] exp_q [$];

    always @(posedge clock) imp_ena_seen <= imp_if.ena;

    always @(negedge clock) begin
        if (imp_if.out_valid === 1'b1 && imp_ena_seen === 1'b1) got_q.push_back(imp_if.y_out);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_got(input string tag);
        check_eq({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check_eq($sformatf("%s_y%0d", tag, i),
                     (i < got_q.size()) ? {16'h0, got_q[i]} : 32'hDEADBEEF, {16'h0, exp_q[i]});
        end
    endtask

    task automatic imp_step(input logic e, input logic v, input logic [15:0] x);
        imp_if.ena      = e;
        imp_if.in_valid = v;
        imp_if.x_in     = x;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        imp_if.in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        got_q.delete();
    endtask

    task automatic load_impulse_exp();
        exp_q = '{16'h0001, 16'hFFFD, 16'h0003, 16'hFFFF, 16'h0000};
    endtask

    task automatic run_impulse(input string tag);
        got_q.delete();
        load_impulse_exp();
        imp_step(1'b1, 1'b1, 16'd1);
        check_eq({tag, "_ov_e0"}, imp_if.out_valid, 0);
        imp_step(1'b1, 1'b1, 16'd0);
        check_eq({tag, "_ov_e1"}, imp_if.out_valid, 0);
        imp_step(1'b1, 1'b1, 16'd0);
        check_eq({tag, "_ov_e2"}, imp_if.out_valid, 1);
        check_eq({tag, "_y_e2"}, imp_if.y_out, 16'h0001);
        imp_step(1'b1, 1'b1, 16'd0);
        imp_step(1'b1, 1'b1, 16'd0);
        for (int i = 0; i < 4; i++) imp_step(1'b1, 1'b0, 16'd0);
        check_got(tag);
    endtask

    logic        gap_v [14] = '{1, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    logic [15:0] gap_x [14] = '{16'h0001, 16'h5A5A, 16'h0000, 16'h5A5A, 16'h5A5A, 16'h0000,
                                16'h0000, 16'h0000, 16'h5A5A, 16'h5A5A, 16'h5A5A, 16'h5A5A,
                                16'h5A5A, 16'h5A5A};
    logic [15:0] dly_exp  [5] = '{16'd0, 16'd1, 16'd2, 16'd2, 16'd2};
    logic [15:0] wrap_x   [3] = '{16'h7FFF, 16'h8000, 16'h7FFF};
    logic [15:0] wrap_exp [3] = '{16'h7FFF, 16'h0001, 16'hFFFF};

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        imp_if.ena  = 1'b1; imp_if.in_valid  = 1'b0; imp_if.x_in  = '0;
        dly_if.ena  = 1'b1; dly_if.in_valid  = 1'b0; dly_if.x_in  = '0;
        wrap_if.ena = 1'b1; wrap_if.in_valid = 1'b0; wrap_if.x_in = '0;
        @(posedge clock);
        #1;
        check_eq("rst_imp_ov", imp_if.out_valid, 0);
        check_eq("rst_imp_y", imp_if.y_out, 0);
        check_eq("rst_dly_ov", dly_if.out_valid, 0);
        check_eq("rst_dly_y", dly_if.y_out, 0);
        check_eq("rst_wrap_ov", wrap_if.out_valid, 0);
        check_eq("rst_wrap_y", wrap_if.y_out, 0);
        reset = 1'b0;

        run_impulse("imp");

        // Step of 5: (1 - z^-1)^3 gives 5, -10, 5, then zeros.
        do_reset();
        exp_q = '{16'h0005, 16'hFFF6, 16'h0005, 16'h0000, 16'h0000, 16'h0000};
        for (int i = 0; i < 6; i++) imp_step(1'b1, 1'b1, 16'd5);
        for (int i = 0; i < 4; i++) imp_step(1'b1, 1'b0, 16'd0);
        check_got("step");

        // Gapped impulse with zero-valued samples and junk data on idle cycles.
        do_reset();
        load_impulse_exp();
        for (int c = 0; c < 14; c++) begin
            imp_step(1'b1, gap_v[c], gap_x[c]);
            check_eq($sformatf("gap_ov_e%0d", c), imp_if.out_valid, (c >= 2) ? gap_v[c-2] : 1'b0);
        end
        check_got("gap");

        // Enable drop mid-stream: outputs freeze and offered samples are dropped.
        do_reset();
        load_impulse_exp();
        imp_step(1'b1, 1'b1, 16'd1);
        imp_step(1'b1, 1'b1, 16'd0);
        imp_step(1'b1, 1'b1, 16'd0);
        check_eq("ena_pre_ov", imp_if.out_valid, 1);
        for (int i = 0; i < 4; i++) begin
            imp_step(1'b0, 1'b1, 16'h7777);
            check_eq($sformatf("ena_hold_ov%0d", i), imp_if.out_valid, 1);
            check_eq($sformatf("ena_hold_y%0d", i), imp_if.y_out, 16'h0001);
        end
        imp_step(1'b1, 1'b1, 16'd0);
        imp_step(1'b1, 1'b1, 16'd0);
        for (int i = 0; i < 4; i++) imp_step(1'b1, 1'b0, 16'd0);
        check_got("ena");

        // Reset mid-stream flushes in-flight samples; a fresh impulse must match the first run.
        do_reset();
        imp_step(1'b1, 1'b1, 16'd1);
        imp_step(1'b1, 1'b1, 16'd0);
        imp_if.in_valid = 1'b1;
        imp_if.x_in     = 16'd0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_eq("midrst_ov", imp_if.out_valid, 0);
        check_eq("midrst_y", imp_if.y_out, 0);
        reset = 1'b0;
        run_impulse("midrst");

        // Differential delay 2, single stage: ramp input.
        for (int i = 0; i < 5; i++) begin
            dly_if.in_valid = 1'b1;
            dly_if.x_in     = 16'(i);
            @(posedge clock);
            #1;
            check_eq($sformatf("dly_ov%0d", i), dly_if.out_valid, 1);
            check_eq($sformatf("dly_y%0d", i), dly_if.y_out, dly_exp[i]);
        end
        dly_if.in_valid = 1'b0;

        // Modular wrap-around, single stage, delay 1.
        for (int i = 0; i < 3; i++) begin
            wrap_if.in_valid = 1'b1;
            wrap_if.x_in     = wrap_x[i];
            @(posedge clock);
            #1;
            check_eq($sformatf("wrap_ov%0d", i), wrap_if.out_valid, 1);
            check_eq($sformatf("wrap_y%0d", i), wrap_if.y_out, wrap_exp[i]);
        end
        wrap_if.in_valid = 1'b0;
        @(posedge clock);
        #1;
        check_eq("wrap_idle_ov", wrap_if.out_valid, 0);
        check_eq("wrap_idle_y", wrap_if.y_out, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
